// File: rtl/bcharger_ctrl.sv
// Supervisor/sequencer for the bcharger FSM: comparator deglitch, charger reset control,
// per-phase safety timer and fault latching. Timer present only with BCHARGER_CTRL_TIMER_EN.
module bcharger_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16,
  parameter int TRKL_MAX   = 1000,
  parameter int FAST_MAX   = 20000,
  parameter int VCONST_MAX = 10000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       vtrkl_raw,
  input  logic       vterm_raw,
  input  logic       iterm_raw,
  input  logic       vrchrg_raw,
  input  logic       trkl,
  input  logic       fast,
  input  logic       vconst,
  input  logic       done,
  output logic       vtrkl,
  output logic       vterm,
  output logic       iterm,
  output logic       vrchrg,
  output logic       chg_reset,
  output logic       busy,
  output logic       fault,
  output logic [2:0] fault_code
);

  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_DONE, S_FAULT} state_t;

  if (DEB_CYCLES < 1 || DEB_CYCLES > 15 ||
      longint'(TRKL_MAX) >= (longint'(1) << CNT_W) ||
      longint'(FAST_MAX) >= (longint'(1) << CNT_W) ||
      longint'(VCONST_MAX) >= (longint'(1) << CNT_W)) begin : g_bad_param
    $error("bcharger_ctrl: parameter out of range");
  end

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      flag_q, flag_d;
  logic [3:0][3:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]      ph;
  logic            ph_multi, ph_one;
  logic            zero_q, zero_d;
  logic            chg_reset_q, chg_reset_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  logic [2:0]      fault_code_q, fault_code_d;
  logic            timeout;
  logic [2:0]      to_code;

  assign raw = {vtrkl_raw, vterm_raw, iterm_raw, vrchrg_raw};

  // Output follows the synchronized flag only after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    flag_d    = flag_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != flag_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          flag_d[i] = ~flag_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign ph       = {trkl, fast, vconst, done};
  assign ph_multi = (ph & (ph - 4'd1)) != 4'd0;
  assign ph_one   = (ph != 4'd0) && !ph_multi;
  assign zero_d   = (state_q == S_CHARGE) && (ph == 4'd0);

`ifdef BCHARGER_CTRL_TIMER_EN
  localparam logic [CNT_W-1:0] TRKL_LIM   = CNT_W'(TRKL_MAX);
  localparam logic [CNT_W-1:0] FAST_LIM   = CNT_W'(FAST_MAX);
  localparam logic [CNT_W-1:0] VCONST_LIM = CNT_W'(VCONST_MAX);

  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       prev_ph_q;

  // Limits are only compared while the phase is stable, so a count left over from the
  // previous phase never trips the new phase's limit on the changeover cycle.
  always_comb begin
    timer_d = '0;
    timeout = 1'b0;
    to_code = 3'd0;
    if (state_q == S_CHARGE && ph == prev_ph_q) begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
      if (trkl && timer_q == TRKL_LIM) begin
        timeout = 1'b1;
        to_code = 3'd1;
      end else if (fast && timer_q == FAST_LIM) begin
        timeout = 1'b1;
        to_code = 3'd2;
      end else if (vconst && timer_q == VCONST_LIM) begin
        timeout = 1'b1;
        to_code = 3'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      prev_ph_q <= '0;
    end else begin
      timer_q   <= timer_d;
      prev_ph_q <= ph;
    end
  end
`else
  assign timeout = 1'b0;
  assign to_code = 3'd0;
`endif

  // en=0 wins over everything; fault detection wins over done/recharge moves.
  always_comb begin
    state_d      = state_q;
    fault_code_d = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_CHARGE;
      end
      S_CHARGE: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (ph_multi || (ph == 4'd0 && zero_q)) begin
          state_d      = S_FAULT;
          fault_code_d = 3'd4;
        end else if (timeout) begin
          state_d      = S_FAULT;
          fault_code_d = to_code;
        end else if (done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (ph_multi) begin
          state_d      = S_FAULT;
          fault_code_d = 3'd4;
        end else if (ph_one && !done) begin
          state_d = S_CHARGE;
        end
      end
      S_FAULT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          fault_code_d = fault_code_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    chg_reset_d = (state_d == S_IDLE) || (state_d == S_FAULT);
    busy_d      = (state_d == S_CHARGE) || (state_d == S_DONE);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      flag_q       <= '0;
      deb_cnt_q    <= '0;
      zero_q       <= 1'b0;
      chg_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      flag_q       <= flag_d;
      deb_cnt_q    <= deb_cnt_d;
      zero_q       <= zero_d;
      chg_reset_q  <= chg_reset_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign {vtrkl, vterm, iterm, vrchrg} = flag_q;
  assign chg_reset  = chg_reset_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_bcharger_ctrl.sv
// Directed self-checking bench for bcharger_ctrl (DEB_CYCLES=2, limits 20/30/25).
module tb_bcharger_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       vtrkl_raw, vterm_raw, iterm_raw, vrchrg_raw;
  logic       trkl, fast, vconst, done;
  logic       vtrkl, vterm, iterm, vrchrg;
  logic       chg_reset, busy, fault;
  logic [2:0] fault_code;

  int total  = 0;
  int passed = 0;

  localparam logic [3:0] PH_T = 4'b1000;
  localparam logic [3:0] PH_F = 4'b0100;
  localparam logic [3:0] PH_V = 4'b0010;
  localparam logic [3:0] PH_D = 4'b0001;

  // {2'b0, chg_reset, busy, fault, fault_code}
  localparam logic [7:0] O_IDLE = 8'h20;
  localparam logic [7:0] O_RUN  = 8'h10;
  localparam logic [7:0] O_F1   = 8'h29;
  localparam logic [7:0] O_F2   = 8'h2A;
  localparam logic [7:0] O_F3   = 8'h2B;
  localparam logic [7:0] O_F4   = 8'h2C;

  always #5 clk = ~clk;

  bcharger_ctrl #(
    .DEB_CYCLES(2), .CNT_W(16), .TRKL_MAX(20), .FAST_MAX(30), .VCONST_MAX(25)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .vtrkl_raw(vtrkl_raw), .vterm_raw(vterm_raw), .iterm_raw(iterm_raw), .vrchrg_raw(vrchrg_raw),
    .trkl(trkl), .fast(fast), .vconst(vconst), .done(done),
    .vtrkl(vtrkl), .vterm(vterm), .iterm(iterm), .vrchrg(vrchrg),
    .chg_reset(chg_reset), .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  function automatic logic [7:0] outs();
    return {2'b00, chg_reset, busy, fault, fault_code};
  endfunction

  function automatic logic [7:0] flags();
    return {4'd0, vtrkl, vterm, iterm, vrchrg};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ph(input logic [3:0] p);
    {trkl, fast, vconst, done} = p;
  endtask

`ifdef BCHARGER_CTRL_TIMER_EN
  task automatic run_timeout(input string tag, input logic [3:0] p, input int lim,
                             input logic [7:0] fexp);
    set_ph(p);
    en = 1'b1;
    tick();
    chk({tag, "_entry"}, outs(), O_RUN);
    ticks(lim);
    chk({tag, "_at_limit"}, outs(), O_RUN);
    tick();
    chk({tag, "_fault"}, outs(), fexp);
    ticks(5);
    chk({tag, "_held"}, outs(), fexp);
    en = 1'b0;
    tick();
    chk({tag, "_clear"}, outs(), O_IDLE);
    set_ph(4'd0);
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    {vtrkl_raw, vterm_raw, iterm_raw, vrchrg_raw} = 4'd0;
    set_ph(4'd0);
    #12;
    chk("reset_outs", outs(), O_IDLE);
    chk("reset_flags", flags(), 8'h00);
    reset_n = 1'b1;
    tick();

    // Deglitch: single-cycle pulse suppressed
    vterm_raw = 1'b1;
    tick();
    vterm_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("deb_pulse", {7'd0, vterm}, 8'h00);
    end

    // Deglitch: held level appears 4 edges after the raw edge, both directions
    vterm_raw = 1'b1;
    ticks(3);
    chk("deb_rise_e3", {7'd0, vterm}, 8'h00);
    tick();
    chk("deb_rise_e4", {7'd0, vterm}, 8'h01);
    tick();
    vterm_raw = 1'b0;
    ticks(3);
    chk("deb_fall_e3", {7'd0, vterm}, 8'h01);
    tick();
    chk("deb_fall_e4", flags(), 8'h00);

    // Normal charge trkl 10 -> fast 15 -> vconst 12 -> done
    set_ph(PH_T);
    en = 1'b1;
    tick();
    chk("en_rise", outs(), O_RUN);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("run_trkl", outs(), O_RUN);
    end
    set_ph(PH_F);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("run_fast", outs(), O_RUN);
    end
    set_ph(PH_V);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("run_vconst", outs(), O_RUN);
    end
    set_ph(PH_D);
    tick();
    chk("done_entry", outs(), O_RUN);
    // An all-zero phase would fault in CHARGE; DONE tolerates it
    set_ph(4'd0);
    ticks(3);
    chk("done_zero_ok", outs(), O_RUN);
    set_ph(PH_T);
    tick();
    chk("recharge", outs(), O_RUN);
`ifdef BCHARGER_CTRL_TIMER_EN
    ticks(20);
    chk("recharge_t20", outs(), O_RUN);
    tick();
    chk("recharge_timeout", outs(), O_F1);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("no_timer", outs(), O_RUN);
    end
`endif
    en = 1'b0;
    tick();
    chk("en_low_idle", outs(), O_IDLE);
    set_ph(4'd0);

`ifdef BCHARGER_CTRL_TIMER_EN
    run_timeout("to_trkl", PH_T, 20, O_F1);
    run_timeout("to_fast", PH_F, 30, O_F2);
    run_timeout("to_vconst", PH_V, 25, O_F3);

    // Timeout cycle coincides with en=0
    set_ph(PH_T);
    en = 1'b1;
    tick();
    ticks(20);
    chk("prio_pre", outs(), O_RUN);
    en = 1'b0;
    tick();
    chk("prio_en_timeout", outs(), O_IDLE);
    ticks(3);
    chk("prio_after", outs(), O_IDLE);
    set_ph(4'd0);
`endif

    // Illegal: two phase bits
    set_ph(PH_F);
    en = 1'b1;
    tick();
    chk("ill_entry", outs(), O_RUN);
    set_ph(4'b0110);
    tick();
    chk("illegal_multi", outs(), O_F4);
    en = 1'b0;
    tick();
    chk("ill_clear", outs(), O_IDLE);

    // Illegal: all zero for two cycles
    set_ph(PH_T);
    en = 1'b1;
    tick();
    set_ph(4'd0);
    tick();
    chk("zero_1cycle", outs(), O_RUN);
    tick();
    chk("illegal_zero", outs(), O_F4);
    en = 1'b0;
    tick();
    chk("zero_clear", outs(), O_IDLE);

    // Asynchronous reset mid-fast
    vrchrg_raw = 1'b1;
    set_ph(PH_F);
    en = 1'b1;
    ticks(6);
    chk("pre_reset_vrchrg", flags(), 8'h01);
    chk("pre_reset_run", outs(), O_RUN);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(), O_IDLE);
    chk("async_reset_flags", flags(), 8'h00);
    vrchrg_raw = 1'b0;
    set_ph(PH_T);
    reset_n = 1'b1;
    tick();
    chk("post_reset_charge", outs(), O_RUN);
    set_ph(4'b0110);
    tick();
    chk("pre_reset_fault", outs(), O_F4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_clears_fault", outs(), O_IDLE);
    reset_n = 1'b1;
    en = 1'b0;
    set_ph(4'd0);
    tick();
    chk("final_idle", outs(), O_IDLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
